// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: op_code encodings and FSM state type shared by the ALU decoder.
package alu_dec_pkg;
   localparam logic [3:0] OP_NEG_A = 4'd0;
   localparam logic [3:0] OP_NEG_B = 4'd1;
   localparam logic [3:0] OP_NOT_A = 4'd2;
   localparam logic [3:0] OP_NOT_B = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd5;
   localparam logic [3:0] OP_INC   = 4'd6;
   localparam logic [3:0] OP_DEC   = 4'd7;
   localparam logic [3:0] OP_MUL   = 4'd8;
   localparam logic [3:0] OP_RSUB  = 4'd9;
   localparam logic [3:0] OP_AND   = 4'd10;
   localparam logic [3:0] OP_OR    = 4'd11;
   localparam logic [3:0] OP_NAND  = 4'd12;
   localparam logic [3:0] OP_NOR   = 4'd13;
   localparam logic [3:0] OP_XOR   = 4'd14;
   localparam logic [3:0] OP_XNOR  = 4'd15;
   typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-add-3 binary to BCD, one bit per cycle after load.
// done is high during the final shift cycle; bcd updates at that edge and then holds.
module bin2bcd_seq #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int SW = 4*DIGITS + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   logic [SW-1:0] sr, adj;
   logic [CW-1:0] cnt;
   always_comb begin
      adj = sr;
      for (int i = 0; i < DIGITS; i++)
         if (sr[WIDTH+4*i +: 4] > 4'd4) adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
   end
   assign busy = cnt != '0;
   assign done = cnt == CW'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
         bcd <= '0;
      end else if (load) begin
         sr  <= {{(4*DIGITS){1'b0}}, bin};
         cnt <= CW'(WIDTH);
      end else if (busy) begin
         sr  <= adj << 1;
         cnt <= cnt - CW'(1);
         if (done) bcd <= adj[SW-2 -: 4*DIGITS];
      end
   end
endmodule

// File: rtl/param_alu_decoder.sv
// param_alu_decoder: captures one ALU operation on start, computes sign/magnitude,
// then converts the magnitude to BCD with a leading sign nibble.
module param_alu_decoder
   import alu_dec_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        a,
   input  logic [WIDTH-1:0]        b,
   input  logic [3:0]              op_code,
   input  logic                    counter_mode,
   input  logic                    count_en,
   input  logic                    start,
   output logic [2*WIDTH+3:0]      instr_code,
   output logic [WIDTH-1:0]        result,
   output logic                    c_out,
   output logic [4*DIGITS+3:0]     bcd,
   output logic                    busy,
   output logic                    done
);
   state_t state, nxt;
   logic [3:0] op;
   logic [WIDTH-1:0] aa, bb, r, cnt, cnt_snap;
   logic [WIDTH:0] sum, inc;
   logic [2*WIDTH-1:0] prod;
   logic [4*DIGITS-1:0] conv_bcd;
   logic mode, sign, sign_r, c_r, bcd_sign, conv_busy, conv_done;
   assign {op, aa, bb} = instr_code;
   assign sum  = {1'b0, aa} + {1'b0, bb};
   assign inc  = {1'b0, aa} + (WIDTH+1)'(1);
   assign prod = {{WIDTH{1'b0}}, aa} * {{WIDTH{1'b0}}, bb};
   always_comb begin
      r      = '0;
      sign_r = 1'b0;
      c_r    = 1'b0;
      if (mode) r = cnt_snap;
      else case (op)
         OP_NEG_A: begin r = aa; sign_r = |aa; end
         OP_NEG_B: begin r = bb; sign_r = |bb; end
         OP_NOT_A: r = ~aa;
         OP_NOT_B: r = ~bb;
         OP_ADD:   {c_r, r} = sum;
         OP_SUB:   begin sign_r = aa < bb; c_r = sign_r; r = sign_r ? bb - aa : aa - bb; end
         OP_INC:   {c_r, r} = inc;
         OP_DEC:   begin sign_r = ~|aa; c_r = sign_r; r = sign_r ? WIDTH'(1) : aa - WIDTH'(1); end
         OP_MUL:   begin r = prod[WIDTH-1:0]; c_r = |prod[2*WIDTH-1:WIDTH]; end
         OP_RSUB:  begin sign_r = bb < aa; c_r = sign_r; r = sign_r ? aa - bb : bb - aa; end
         OP_AND:   r = aa & bb;
         OP_OR:    r = aa | bb;
         OP_NAND:  r = ~(aa & bb);
         OP_NOR:   r = ~(aa | bb);
         OP_XOR:   r = aa ^ bb;
         default:  r = ~(aa ^ bb);
      endcase
   end
   always_comb
      nxt = (state == IDLE) ? (start ? EXEC : IDLE) :
            (state == EXEC) ? CONV :
            (state == CONV) ? (conv_done ? DONE : CONV) : IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         cnt_snap   <= '0;
         mode       <= 1'b0;
         instr_code <= '0;
         result     <= '0;
         sign       <= 1'b0;
         c_out      <= 1'b0;
         bcd_sign   <= 1'b0;
      end else begin
         if (count_en) cnt <= cnt + WIDTH'(1);
         if (state == IDLE && start) begin
            instr_code <= {op_code, a, b};
            mode       <= counter_mode;
            cnt_snap   <= cnt;
         end
         if (state == EXEC) begin
            result <= r;
            sign   <= sign_r;
            c_out  <= c_r;
         end
         if (conv_done) bcd_sign <= sign;
      end
   end
   // the converter is loaded from the same combinational value that EXEC registers
   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
      .clk(clk),
      .rst(rst),
      .load(state == EXEC),
      .bin(r),
      .busy(conv_busy),
      .done(conv_done),
      .bcd(conv_bcd)
   );
   assign bcd  = {3'b000, bcd_sign, conv_bcd};
   assign busy = (state != IDLE) | conv_busy;
   assign done = state == DONE;
endmodule

// File: tb/tb_param_alu_decoder.sv
// tb_param_alu_decoder: table vectors, hand-written corner sequences and a randomized
// run against an integer-arithmetic model, on a 4-bit and an 8-bit instance.
module tb_param_alu_decoder;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] op = '0;
   logic cm = 1'b0, ce = 1'b0, st4 = 1'b0, st8 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [11:0] instr4, bcd4;
   logic [3:0] res4;
   logic c4, busy4, done4;
   logic [19:0] instr8;
   logic [15:0] bcd8;
   logic [7:0] res8;
   logic c8, busy8, done8;
   int n_chk = 0, n_fail = 0;
   int m4 = 0, m8 = 0;

   typedef struct {int w; int op; int a; int b; int r; int c; int bcd;} vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) begin m4 <= 0; m8 <= 0; end
      else if (ce) begin m4 <= (m4 + 1) % 16; m8 <= (m8 + 1) % 256; end

   param_alu_decoder #(.WIDTH(4), .DIGITS(2)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .op_code(op), .counter_mode(cm),
      .count_en(ce), .start(st4), .instr_code(instr4), .result(res4), .c_out(c4),
      .bcd(bcd4), .busy(busy4), .done(done4));

   param_alu_decoder #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .op_code(op), .counter_mode(cm),
      .count_en(ce), .start(st8), .instr_code(instr8), .result(res8), .c_out(c8),
      .bcd(bcd8), .busy(busy8), .done(done8));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic sample(input int w, output int r, output int c, output int bcd,
                         output int ins, output int bsy, output int dn);
      if (w == 4) begin
         r = int'(res4); c = int'(c4); bcd = int'(bcd4); ins = int'(instr4); bsy = int'(busy4); dn = int'(done4);
      end else begin
         r = int'(res8); c = int'(c8); bcd = int'(bcd8); ins = int'(instr8); bsy = int'(busy8); dn = int'(done8);
      end
   endtask

   // signed result from plain integer arithmetic, then folded into sign/magnitude/carry
   task automatic model(input int w, input int o, input int a, input int b, input bit m,
                        input int cnt, output int r, output int c, output int bcd);
      int mx, v, s, p, d;
      mx = (1 << w) - 1;
      d = (w == 4) ? 2 : 3;
      r = 0; s = 0; c = 0; v = 0;
      if (m) r = cnt;
      else case (o)
         0: begin r = a; s = int'(a != 0); end
         1: begin r = b; s = int'(b != 0); end
         2: r = mx - a;
         3: r = mx - b;
         4, 6, 8: begin
            v = (o == 4) ? a + b : (o == 6) ? a + 1 : a * b;
            c = int'(v > mx); r = v % (mx + 1);
         end
         5, 7, 9: begin
            v = (o == 5) ? a - b : (o == 7) ? a - 1 : b - a;
            s = int'(v < 0); c = s; r = (v < 0) ? -v : v;
         end
         10: r = a & b;
         11: r = a | b;
         12: r = mx - (a & b);
         13: r = mx - (a | b);
         14: r = a ^ b;
         default: r = mx - (a ^ b);
      endcase
      bcd = s << (4 * d);
      p = 1;
      for (int i = 0; i < d; i++) begin
         bcd |= ((r / p) % 10) << (4 * i);
         p *= 10;
      end
   endtask

   task automatic run(input string tag, input int w, input int o, input int a, input int b,
                      input bit m, input int er, input int ec, input int ebcd);
      int cyc, r, c, bcd, ins, bsy, dn, r0;
      op = 4'(o); cm = m;
      if (w == 4) begin a4 = 4'(a); b4 = 4'(b); st4 = 1'b1; end
      else begin a8 = 8'(a); b8 = 8'(b); st8 = 1'b1; end
      @(posedge clk); #1;
      st4 = 1'b0; st8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      op = 4'($urandom); cm = 1'($urandom);
      cyc = 1;
      sample(w, r, c, bcd, ins, bsy, dn);
      chk({tag, " busy"}, bsy, 1);
      while (dn == 0 && cyc < 3 * w + 4) begin
         @(posedge clk); #1;
         cyc++;
         sample(w, r, c, bcd, ins, bsy, dn);
      end
      chk({tag, " latency"}, cyc, w + 2);
      chk({tag, " result"}, r, er);
      chk({tag, " c_out"}, c, ec);
      chk({tag, " bcd"}, bcd, ebcd);
      chk({tag, " instr"}, ins, (o << (2 * w)) | (a << w) | b);
      r0 = r;
      @(posedge clk); #1;
      sample(w, r, c, bcd, ins, bsy, dn);
      chk({tag, " done pulse"}, dn, 0);
      chk({tag, " hold"}, r, r0);
   endtask

   initial begin
      int r, c, bcd, ins, bsy, dn, seen, w, o, a, b, er, ec, eb;
      bit m;
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int r, c, bcd, ins, bsy, dn, seen, w, o, a, b, er, ec, eb;
      bit m;
      tbl[0]  = '{4, 4, 9, 6, 15, 0, 'h015};
      tbl[1]  = '{4, 5, 3, 7, 4, 1, 'h104};
      tbl[2]  = '{4, 9, 3, 7, 4, 0, 'h004};
      tbl[3]  = '{4, 7, 0, 5, 1, 1, 'h101};
      tbl[4]  = '{4, 6, 15, 2, 0, 1, 'h000};
      tbl[5]  = '{8, 4, 200, 100, 44, 1, 'h0044};
      tbl[6]  = '{8, 8, 15, 17, 255, 0, 'h0255};
      tbl[7]  = '{4, 0, 5, 3, 5, 0, 'h105};
      tbl[8]  = '{4, 2, 5, 3, 10, 0, 'h010};
      tbl[9]  = '{4, 8, 5, 4, 4, 1, 'h004};
      tbl[10] = '{4, 13, 5, 2, 8, 0, 'h008};
      tbl[11] = '{4, 1, 9, 0, 0, 0, 'h000};

      repeat (2) @(posedge clk);
      #1;
      sample(4, r, c, bcd, ins, bsy, dn);
      chk("rst result", r, 0);
      chk("rst c_out", c, 0);
      chk("rst bcd", bcd, 0);
      chk("rst instr", ins, 0);
      chk("rst busy", bsy, 0);
      chk("rst done", dn, 0);
      sample(8, r, c, bcd, ins, bsy, dn);
      chk("rst8 bcd", bcd, 0);
      chk("rst8 busy", bsy, 0);

      // counter wraps 15 -> 0 -> 1 after 17 enabled cycles
      rst = 1'b0; ce = 1'b1;
      repeat (17) @(posedge clk);
      #1 ce = 1'b0;
      run("cnt_mode", 4, 4, 9, 6, 1'b1, 1, 0, 'h001);

      for (int i = 0; i < 12; i++)
         run($sformatf("vec%0d", i), tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0,
             tbl[i].r, tbl[i].c, tbl[i].bcd);

      // reset in the third CONV cycle aborts the operation
      a4 = 4'd9; b4 = 4'd6; op = 4'd4; cm = 1'b0; st4 = 1'b1;
      @(posedge clk); #1 st4 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      sample(4, r, c, bcd, ins, bsy, dn);
      chk("abort result", r, 0);
      chk("abort c_out", c, 0);
      chk("abort bcd", bcd, 0);
      chk("abort instr", ins, 0);
      chk("abort busy", bsy, 0);
      seen = dn;
      @(posedge clk); #1 rst = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done4) seen++;
      end
      chk("abort no done", seen, 0);

      // second start while busy is dropped
      a4 = 4'd2; b4 = 4'd3; op = 4'd4; st4 = 1'b1;
      @(posedge clk); #1 st4 = 1'b0;
      seen = 0;
      repeat (2) @(posedge clk);
      #1 a4 = 4'd7; b4 = 4'd7; op = 4'd8; st4 = 1'b1;
      @(posedge clk); #1 st4 = 1'b0;
      if (done4) seen++;
      repeat (14) begin
         @(posedge clk); #1;
         if (done4) seen++;
      end
      chk("busy start dones", seen, 1);
      chk("busy start result", int'(res4), 5);
      chk("busy start instr", int'(instr4), 'h423);

      for (int i = 0; i < 45; i++) begin
         w = (i % 3 == 2) ? 8 : 4;
         o = $urandom_range(15, 0);
         a = $urandom_range((1 << w) - 1, 0);
         b = $urandom_range((1 << w) - 1, 0);
         m = (w == 4) && ($urandom_range(3, 0) == 0);
         ce = 1'($urandom_range(1, 0));
         model(w, o, a, b, m, (w == 4) ? m4 : m8, er, ec, eb);
         run($sformatf("rnd%0d", i), w, o, a, b, m, er, ec, eb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
